if_id_ctrl: RTL and testbench

IF_ID_CTRL -- requirements
Module: if_id_ctrl

---
 rtl/if_id_ctrl.sv | 162 ++++++++++++++++
 tb/tb_if_id_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_ctrl.sv
// Fetch stage and IF/ID pipeline register, with load-use stall, a one-entry skid buffer and branch redirect.
// Optional stall/flush performance counters are enabled by defining IF_PERF_CNT_EN.
module if_id_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ex_memRead,
  input  logic [4:0]  ex_write_reg,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        id_valid,
  output logic        stall,
  output logic        id_ex_flush
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_q, instr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] tgt_q, tgt_d;

  logic        hazard;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;

  assign hazard = ex_memRead & id_valid_q & (ex_write_reg != 5'd0) &
                  ((ex_write_reg == instr_q[19:15]) | (ex_write_reg == instr_q[24:20]));
  assign stall       = hazard & ~branch_taken;
  assign id_ex_flush = hazard | branch_taken;
  assign pc_plus4    = pc_q + 32'd4;
  assign br_tgt      = {branch_target[31:2], 2'b00};

  // Gated with rst_n so no request escapes while reset is held.
  assign imem_req  = rst_n & (state_q != HOLD);
  // In DISCARD pc_q still holds the old address; the redirect target waits in tgt_q.
  assign imem_addr = pc_q;
  assign pc_out    = pc_out_q;
  assign instr_out = instr_q;
  assign id_valid  = id_valid_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    pc_d         = pc_q;
    pc_out_d     = pc_out_q;
    instr_d      = instr_q;
    id_valid_d   = id_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    tgt_d        = tgt_q;

    if (branch_taken) begin
      instr_d    = NOP_INSTR;
      id_valid_d = 1'b0;
      tgt_d      = br_tgt;
      if (state_q == HOLD || imem_valid) begin
        pc_d    = br_tgt;
        state_d = FETCH;
      end else begin
        state_d = DISCARD;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (stall) begin
            if (imem_valid) begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_q;
              state_d      = HOLD;
            end
          end else if (imem_valid) begin
            instr_d    = imem_rdata;
            pc_out_d   = pc_q;
            id_valid_d = 1'b1;
            pc_d       = pc_plus4;
          end else begin
            instr_d    = NOP_INSTR;
            id_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d    = skid_instr_q;
            pc_out_d   = skid_pc_q;
            id_valid_d = 1'b1;
            pc_d       = pc_plus4;
            state_d    = FETCH;
          end
        end
        DISCARD: begin
          if (imem_valid) begin
            pc_d    = tgt_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the skid and target registers are reset too, so a reset in HOLD/DISCARD leaves nothing to replay.
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      pc_out_q     <= RESET_PC;
      instr_q      <= NOP_INSTR;
      id_valid_q   <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
      tgt_q        <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_out_q     <= pc_out_d;
      instr_q      <= instr_d;
      id_valid_q   <= id_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      tgt_q        <= tgt_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch_taken && flush_cnt_q != 32'hFFFF_FFFF)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed self-checking bench for if_id_ctrl: streaming fetch, load-use stall, skid buffer,
// branch redirect with DISCARD, PC wrap and reset abandonment.
module tb_if_id_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LU_INSTR = 32'h0020_8033;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ex_memRead;
  logic [4:0]  ex_write_reg;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        id_valid;
  logic        stall;
  logic        id_ex_flush;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  logic        use_fixed;
  logic [31:0] fixed_word;
  int          n_checks = 0;
  int          n_errors = 0;

  // Instruction memory model: returns its own address unless a fixed word is forced.
  assign imem_rdata = use_fixed ? fixed_word : imem_addr;

  if_id_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ex_memRead    (ex_memRead),
    .ex_write_reg  (ex_write_reg),
    .pc_out        (pc_out),
    .instr_out     (instr_out),
    .id_valid      (id_valid),
    .stall         (stall),
    .id_ex_flush   (id_ex_flush)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; imem_valid = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    ex_memRead = 1'b0; ex_write_reg = 5'd0; use_fixed = 1'b0; fixed_word = LU_INSTR;
    #1 rst_n = 1'b0;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_instr", instr_out, NOP);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    tick(); tick();
    check("rst_req_held", {31'd0, imem_req}, 32'd0);

    // Streaming fetch after reset release, rdata = addr
    rst_n = 1'b1; imem_valid = 1'b1;
    #1;
    check("rel_req", {31'd0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'd0);
    tick();
    check("s0_instr", instr_out, 32'd0);
    check("s0_valid", {31'd0, id_valid}, 32'd1);
    tick();
    check("s1_instr", instr_out, 32'd4);
    tick();
    check("s2_instr", instr_out, 32'd8);
    check("s2_pc_out", pc_out, 32'd8);
    check("s2_addr", imem_addr, 32'd12);

    // No response: bubble, pc held
    imem_valid = 1'b0;
    tick();
    check("nv_valid", {31'd0, id_valid}, 32'd0);
    check("nv_instr", instr_out, NOP);
    check("nv_addr", imem_addr, 32'd12);

    // Load-use hazard on rs2
    use_fixed = 1'b1; imem_valid = 1'b1;
    tick();
    check("lu_instr", instr_out, LU_INSTR);
    check("lu_pc_out", pc_out, 32'd12);
    use_fixed = 1'b0; imem_valid = 1'b0; ex_memRead = 1'b1; ex_write_reg = 5'd2;
    #1;
    check("lu_stall", {31'd0, stall}, 32'd1);
    check("lu_flush", {31'd0, id_ex_flush}, 32'd1);
    tick();
    check("lu_hold_instr", instr_out, LU_INSTR);
    check("lu_hold_addr", imem_addr, 32'd16);
    check("lu_hold_valid", {31'd0, id_valid}, 32'd1);
    ex_memRead = 1'b0;
    #1;
    check("lu_drop_stall", {31'd0, stall}, 32'd0);
    ex_memRead = 1'b1; ex_write_reg = 5'd0;
    #1;
    check("x0_stall", {31'd0, stall}, 32'd0);
    check("x0_flush", {31'd0, id_ex_flush}, 32'd0);
    ex_write_reg = 5'd1;
    #1;
    check("rs1_stall", {31'd0, stall}, 32'd1);

    // Stall with a response: skid buffer and HOLD
    ex_write_reg = 5'd2; imem_valid = 1'b1;
    tick();
    check("hold_req", {31'd0, imem_req}, 32'd0);
    check("hold_instr", instr_out, LU_INSTR);
    tick();
    check("hold2_req", {31'd0, imem_req}, 32'd0);
    ex_memRead = 1'b0; imem_valid = 1'b0;
    tick();
    check("skid_instr", instr_out, 32'd16);
    check("skid_pc_out", pc_out, 32'd16);
    check("skid_valid", {31'd0, id_valid}, 32'd1);
    check("skid_addr", imem_addr, 32'd20);
    imem_valid = 1'b1;
    tick();
    check("post_skid_instr", instr_out, 32'd20);
    check("post_skid_addr", imem_addr, 32'd24);

    // Branch with no response: DISCARD
    imem_valid = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0103;
    #1;
    check("br_flush", {31'd0, id_ex_flush}, 32'd1);
    tick();
    check("dis_addr", imem_addr, 32'd24);
    check("dis_req", {31'd0, imem_req}, 32'd1);
    check("dis_instr", instr_out, NOP);
    check("dis_valid", {31'd0, id_valid}, 32'd0);
    branch_taken = 1'b0; imem_valid = 1'b1;
    tick();
    check("drop_instr", instr_out, NOP);
    check("drop_valid", {31'd0, id_valid}, 32'd0);
    check("tgt_addr", imem_addr, 32'h0000_0100);
    tick();
    check("tgt_instr", instr_out, 32'h0000_0100);
    check("tgt_pc_out", pc_out, 32'h0000_0100);

    // PC wrap at the top of the address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    tick();
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_br_valid", {31'd0, id_valid}, 32'd0);
    branch_taken = 1'b0;
    tick();
    check("wrap_instr", instr_out, 32'hFFFF_FFFC);
    check("wrap_next_addr", imem_addr, 32'd0);

    // Branch during HOLD discards the skid entry and beats the stall
    use_fixed = 1'b1;
    tick();
    check("hb_instr", instr_out, LU_INSTR);
    use_fixed = 1'b0; ex_memRead = 1'b1; ex_write_reg = 5'd2;
    tick();
    check("hb_hold_req", {31'd0, imem_req}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    #1;
    check("hb_stall", {31'd0, stall}, 32'd0);
    check("hb_flush", {31'd0, id_ex_flush}, 32'd1);
    tick();
    branch_taken = 1'b0; ex_memRead = 1'b0; imem_valid = 1'b0;
    check("hb_instr_nop", instr_out, NOP);
    check("hb_addr", imem_addr, 32'h0000_0200);
    check("hb_req", {31'd0, imem_req}, 32'd1);
    tick();
    check("hb_no_skid", {31'd0, id_valid}, 32'd0);
    check("hb_no_skid_instr", instr_out, NOP);
`ifdef IF_PERF_CNT_EN
    check("stall_cnt", stall_cnt, 32'd4);
    check("flush_cnt", flush_cnt, 32'd3);
`endif

    // Reset during HOLD abandons the skid entry
    use_fixed = 1'b1; imem_valid = 1'b1;
    tick();
    use_fixed = 1'b0; ex_memRead = 1'b1; ex_write_reg = 5'd2;
    tick();
    check("rh_hold_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rh_req", {31'd0, imem_req}, 32'd0);
    check("rh_instr", instr_out, NOP);
    check("rh_pc_out", pc_out, 32'd0);
    check("rh_valid", {31'd0, id_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
    check("rh_stall_cnt", stall_cnt, 32'd0);
`endif
    ex_memRead = 1'b0; imem_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rh_after_valid", {31'd0, id_valid}, 32'd0);
    check("rh_after_instr", instr_out, NOP);
    check("rh_after_addr", imem_addr, 32'd0);
    imem_valid = 1'b1;
    tick();
    check("rh_fetch0", instr_out, 32'd0);
    check("rh_fetch0_pc", pc_out, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
